// File: rtl/braille_pkg.sv
// Shared braille definitions: dot masks, the 27-entry cell table (space + a..z),
// BCD code helpers and the encoder FSM state type.
package braille_pkg;

  localparam logic [5:0] DOT1 = 6'b000001;
  localparam logic [5:0] DOT2 = 6'b000010;
  localparam logic [5:0] DOT3 = 6'b000100;
  localparam logic [5:0] DOT4 = 6'b001000;
  localparam logic [5:0] DOT5 = 6'b010000;
  localparam logic [5:0] DOT6 = 6'b100000;

  localparam int unsigned CODE_MAX = 26;

  // First decade a..j; the other two decades are derived by adding dots 3 and 3+6
  localparam logic [5:0] CELL_A = DOT1;
  localparam logic [5:0] CELL_B = DOT1 | DOT2;
  localparam logic [5:0] CELL_C = DOT1 | DOT4;
  localparam logic [5:0] CELL_D = DOT1 | DOT4 | DOT5;
  localparam logic [5:0] CELL_E = DOT1 | DOT5;
  localparam logic [5:0] CELL_F = DOT1 | DOT2 | DOT4;
  localparam logic [5:0] CELL_G = DOT1 | DOT2 | DOT4 | DOT5;
  localparam logic [5:0] CELL_H = DOT1 | DOT2 | DOT5;
  localparam logic [5:0] CELL_I = DOT2 | DOT4;
  localparam logic [5:0] CELL_J = DOT2 | DOT4 | DOT5;

  localparam logic [5:0] CELL_TABLE [27] = '{
    6'b000000,
    CELL_A, CELL_B, CELL_C, CELL_D, CELL_E,
    CELL_F, CELL_G, CELL_H, CELL_I, CELL_J,
    CELL_A | DOT3, CELL_B | DOT3, CELL_C | DOT3, CELL_D | DOT3, CELL_E | DOT3,
    CELL_F | DOT3, CELL_G | DOT3, CELL_H | DOT3, CELL_I | DOT3, CELL_J | DOT3,
    CELL_A | DOT3 | DOT6, CELL_B | DOT3 | DOT6,
    DOT2 | DOT4 | DOT5 | DOT6,
    CELL_C | DOT3 | DOT6, CELL_D | DOT3 | DOT6, CELL_E | DOT3 | DOT6
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic bcd_code_valid(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] value;
    value = {x, 3'b000} + {2'b00, x, 1'b0} + {3'b000, y};
    return (x <= 4'd9) && (y <= 4'd9) && (value <= 7'(CODE_MAX));
  endfunction

  // Low five bits of 10*x+y; only meaningful when the code is valid
  function automatic logic [4:0] bcd_code_index(input logic [3:0] x, input logic [3:0] y);
    return {x[1:0], 3'b000} + {x, 1'b0} + {1'b0, y};
  endfunction

endpackage

// File: rtl/braille_cell_lut.sv
// Combinational BCD-to-braille cell lookup; invalid codes yield a blank cell
// with code_ok low.
module braille_cell_lut
  import braille_pkg::*;
(
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic [5:0] dots_next,
  output logic       code_ok
);

  logic [4:0] idx_s;

  assign code_ok = bcd_code_valid(in_x, in_y);
  assign idx_s   = bcd_code_index(in_x, in_y);

  // Table lookup, gated so an out-of-range index never reaches the table
  always_comb begin
    dots_next = 6'b000000;
    if (code_ok) begin
      dots_next = CELL_TABLE[idx_s];
    end else begin
      dots_next = 6'b000000;
    end
  end

endmodule

// File: rtl/bcd_to_braille_encoder.sv
// Accepts BCD character codes over valid/ready and shows each braille cell on a
// registered bus for HOLD_CYCLES, followed by GAP_CYCLES of blank.
module bcd_to_braille_encoder
  import braille_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 200,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic [5:0] dots,
  output logic       cell_valid,
  output logic       cell_done,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic             HAS_GAP   = (GAP_CYCLES > 0);

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [5:0]       dots_r, dots_nxt_s;
  logic             cell_valid_r, cell_valid_nxt_s;
  logic             cell_done_r, cell_done_nxt_s;
  logic             err_pulse_r, err_pulse_nxt_s;
  logic [7:0]       err_count_r, err_count_nxt_s;
  logic [5:0]       lut_dots_s;
  logic             lut_ok_s;
  logic             handshake_s;

  braille_cell_lut u_lut (
    .in_x      (in_x),
    .in_y      (in_y),
    .dots_next (lut_dots_s),
    .code_ok   (lut_ok_s)
  );

  assign in_ready    = (state_r == IDLE);
  assign handshake_s = in_valid && in_ready;

  // Next-state, counter and output-register values
  always_comb begin
    next_state_s     = state_r;
    cnt_nxt_s        = cnt_r;
    dots_nxt_s       = dots_r;
    cell_valid_nxt_s = cell_valid_r;
    err_pulse_nxt_s  = 1'b0;
    err_count_nxt_s  = err_count_r;
    case (state_r)
      IDLE: begin
        if (handshake_s && lut_ok_s) begin
          dots_nxt_s       = lut_dots_s;
          cell_valid_nxt_s = 1'b1;
          cnt_nxt_s        = HOLD_LOAD;
          next_state_s     = SHOW;
        end else if (handshake_s) begin
          err_pulse_nxt_s = 1'b1;
          if (err_count_r != 8'hFF) begin
            err_count_nxt_s = err_count_r + 8'd1;
          end else begin
            err_count_nxt_s = err_count_r;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      SHOW: begin
        if (cnt_r == '0) begin
          dots_nxt_s       = 6'b000000;
          cell_valid_nxt_s = 1'b0;
          if (HAS_GAP) begin
            cnt_nxt_s    = GAP_LOAD;
            next_state_s = GAP;
          end else begin
            cnt_nxt_s    = '0;
            next_state_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r - 1'b1;
        end
      end
      GAP: begin
        if (cnt_r == '0) begin
          next_state_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 1'b1;
        end
      end
      default: begin
        next_state_s     = IDLE;
        cnt_nxt_s        = '0;
        dots_nxt_s       = 6'b000000;
        cell_valid_nxt_s = 1'b0;
      end
    endcase
    // Registered so the pulse lines up with the final SHOW cycle
    cell_done_nxt_s = (next_state_s == SHOW) && (cnt_nxt_s == '0);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      dots_r       <= 6'b000000;
      cell_valid_r <= 1'b0;
      cell_done_r  <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_count_r  <= 8'd0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= cnt_nxt_s;
      dots_r       <= dots_nxt_s;
      cell_valid_r <= cell_valid_nxt_s;
      cell_done_r  <= cell_done_nxt_s;
      err_pulse_r  <= err_pulse_nxt_s;
      err_count_r  <= err_count_nxt_s;
    end
  end

  assign dots       = dots_r;
  assign cell_valid = cell_valid_r;
  assign cell_done  = cell_done_r;
  assign err_pulse  = err_pulse_r;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_bcd_to_braille_encoder.sv
// Directed bench for bcd_to_braille_encoder with HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_bcd_to_braille_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_x = 4'd0;
  logic [3:0] in_y = 4'd0;
  logic [5:0] dots;
  logic       cell_valid;
  logic       cell_done;
  logic       err_pulse;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] EXP_A = 6'b000001;
  localparam logic [5:0] EXP_W = 6'b111010;
  localparam logic [5:0] EXP_Z = 6'b110101;
  localparam logic [5:0] EXP_K = 6'b000101;

  bcd_to_braille_encoder #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .dots       (dots),
    .cell_valid (cell_valid),
    .cell_done  (cell_done),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_wait_idle: in_ready=%b required 1 within 30 cycles", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dots, cell_valid, cell_done, err_pulse, err_count, in_ready} !== {6'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: dots=%b cv=%b cd=%b ep=%b ec=%0d rdy=%b required 0/0/0/0/0/1",
               dots, cell_valid, cell_done, err_pulse, err_count, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_letter_a();
    in_valid = 1'b1; in_x = 4'd0; in_y = 4'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (dots !== EXP_A || cell_valid !== 1'b1 || in_ready !== 1'b0 || cell_done !== (k == 3)) begin
        n_fail++;
        $display("FAIL a_show[%0d]: dots=%b cv=%b rdy=%b cd=%b required %b/1/0/%b",
                 k, dots, cell_valid, in_ready, cell_done, EXP_A, (k == 3));
      end
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      n_checks++;
      if (dots !== 6'd0 || cell_valid !== 1'b0 || cell_done !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL a_gap[%0d]: dots=%b cv=%b cd=%b rdy=%b required 0/0/0/0",
                 g, dots, cell_valid, cell_done, in_ready);
      end
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || dots !== 6'd0) begin
      n_fail++;
      $display("FAIL a_idle: rdy=%b dots=%b required 1/000000", in_ready, dots);
    end
  endtask

  task automatic test_back_to_back();
    int gap_seen = -1;
    in_valid = 1'b1; in_x = 4'd2; in_y = 4'd3;
    @(negedge clk);
    n_checks++;
    if (dots !== EXP_W || cell_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_w: dots=%b cv=%b required %b/1", dots, cell_valid, EXP_W);
    end
    in_y = 4'd6;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        gap_seen = i;
        break;
      end
    end
    n_checks++;
    if (gap_seen != 6) begin
      n_fail++;
      $display("FAIL b2b_spacing: next accept %0d cycles after first, required 7", gap_seen + 1);
    end
    @(negedge clk);
    n_checks++;
    if (dots !== EXP_Z || cell_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_z: dots=%b cv=%b required %b/1", dots, cell_valid, EXP_Z);
    end
    in_valid = 1'b0; in_x = 4'd0; in_y = 4'd1;
    @(negedge clk);
    n_checks++;
    if (dots !== EXP_Z) begin
      n_fail++;
      $display("FAIL b2b_hold_inputs_ignored: dots=%b required %b", dots, EXP_Z);
    end
    wait_idle("b2b");
  endtask

  task automatic test_space();
    in_valid = 1'b1; in_x = 4'd0; in_y = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (dots !== 6'd0 || cell_valid !== 1'b1 || err_pulse !== 1'b0 || err_count !== 8'd0) begin
        n_fail++;
        $display("FAIL space[%0d]: dots=%b cv=%b ep=%b ec=%0d required 0/1/0/0",
                 k, dots, cell_valid, err_pulse, err_count);
      end
    end
    wait_idle("space");
  endtask

  task automatic test_invalid();
    in_valid = 1'b1; in_x = 4'd2; in_y = 4'd7;
    @(negedge clk);
    n_checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || dots !== 6'd0 || in_ready !== 1'b1 || cell_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_27: ep=%b ec=%0d dots=%b rdy=%b cv=%b required 1/1/0/1/0",
               err_pulse, err_count, dots, in_ready, cell_valid);
    end
    in_x = 4'hA; in_y = 4'd0;
    @(negedge clk);
    n_checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd2 || dots !== 6'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_A0: ep=%b ec=%0d dots=%b rdy=%b required 1/2/0/1",
               err_pulse, err_count, dots, in_ready);
    end
    in_x = 4'd0; in_y = 4'hB;
    @(negedge clk);
    n_checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd3 || dots !== 6'd0) begin
      n_fail++;
      $display("FAIL invalid_0B: ep=%b ec=%0d dots=%b required 1/3/0", err_pulse, err_count, dots);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd3) begin
      n_fail++;
      $display("FAIL invalid_after: ep=%b ec=%0d required 0/3", err_pulse, err_count);
    end
  endtask

  task automatic test_reset_mid_show();
    in_valid = 1'b1; in_x = 4'd1; in_y = 4'd1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (dots !== EXP_K || cell_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL k_show: dots=%b cv=%b required %b/1", dots, cell_valid, EXP_K);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dots !== 6'd0 || cell_valid !== 1'b0 || cell_done !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: dots=%b cv=%b cd=%b rdy=%b ec=%0d required 0/0/0/1/0",
               dots, cell_valid, cell_done, in_ready, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || err_count !== 8'd0 || dots !== 6'd0) begin
      n_fail++;
      $display("FAIL after_reset: rdy=%b ec=%0d dots=%b required 1/0/0", in_ready, err_count, dots);
    end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_x = 4'hF; in_y = 4'hF;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == 254) begin
        n_checks++;
        if (err_count !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_254: ec=%0d required 254", err_count);
        end
      end else if (i >= 255) begin
        n_checks++;
        if (err_count !== 8'd255 || err_pulse !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_%0d: ec=%0d ep=%b required 255/1", i, err_count, err_pulse);
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_count !== 8'd255 || err_pulse !== 1'b0 || dots !== 6'd0) begin
      n_fail++;
      $display("FAIL sat_hold: ec=%0d ep=%b dots=%b required 255/0/0", err_count, err_pulse, dots);
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_back_to_back();
    test_space();
    test_invalid();
    test_reset_mid_show();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
